// File: rtl/global_avg_pool.sv
// Global average pooling: per-channel sums over PIXELS positions, then a rounded
// reciprocal-multiply average streamed out OPS_PER_CYCLE channels per beat.
module global_avg_pool #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned OPS_PER_CYCLE = 10,
    parameter int unsigned CHANNELS      = 1024,
    parameter int unsigned PIXELS        = 49,
    parameter int unsigned ACC_WIDTH     = 16,
    parameter int unsigned RECIP         = 1337,
    parameter int unsigned SHIFT         = 16
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [OPS_PER_CYCLE-1:0][DATA_WIDTH-1:0]  in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [OPS_PER_CYCLE-1:0][DATA_WIDTH-1:0]  out_data,
    output logic                                      out_last,
    output logic                                      frame_done
);

    localparam int unsigned BEATS  = (CHANNELS + OPS_PER_CYCLE - 1) / OPS_PER_CYCLE;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int unsigned CH_W   = $clog2(BEATS * OPS_PER_CYCLE + 1);
    localparam int unsigned IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned MUL_W  = ACC_WIDTH + $clog2(RECIP + 1);
    localparam int unsigned RND_W  = MUL_W + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(PIXELS - 1);

    typedef enum logic {
        ACCUM,
        OUTPUT
    } state_t;

    state_t              state, state_nxt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   out_cnt;
    logic [PIX_W-1:0]    pix_cnt;
    logic                in_fire;
    logic                out_fire;
    logic [CH_W-1:0]     in_base;
    logic [CH_W-1:0]     out_base;
    logic [CH_W-1:0]     in_ch  [OPS_PER_CYCLE];
    logic [CH_W-1:0]     out_ch [OPS_PER_CYCLE];
    logic [ACC_WIDTH-1:0] acc   [CHANNELS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        frame_done = 1'b0;
        in_fire    = 1'b0;
        out_fire   = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                in_fire  = in_valid;
                if (in_fire && beat_cnt == LAST_BEAT && pix_cnt == LAST_PIX)
                    state_nxt = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                out_last  = (out_cnt == LAST_BEAT);
                out_fire  = out_ready;
                if (out_fire && out_last) begin
                    frame_done = 1'b1;
                    state_nxt  = ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
            pix_cnt  <= '0;
            out_cnt  <= '0;
        end else begin
            if (in_fire) begin
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt <= '0;
                    pix_cnt  <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if (out_fire)
                out_cnt <= out_last ? '0 : out_cnt + 1'b1;
        end
    end

    always_comb begin
        in_base  = CH_W'(beat_cnt) * CH_W'(OPS_PER_CYCLE);
        out_base = CH_W'(out_cnt) * CH_W'(OPS_PER_CYCLE);
        for (int unsigned l = 0; l < OPS_PER_CYCLE; l++) begin
            in_ch[l]  = in_base + CH_W'(l);
            out_ch[l] = out_base + CH_W'(l);
        end
    end

    // Pixel 0 overwrites, so no clear pass is needed between frames.
    always_ff @(posedge clock) begin
        if (in_fire) begin
            for (int unsigned l = 0; l < OPS_PER_CYCLE; l++) begin
                if (in_ch[l] < CH_W'(CHANNELS)) begin
                    if (pix_cnt == '0)
                        acc[in_ch[l][IDX_W-1:0]] <= ACC_WIDTH'(in_data[l]);
                    else
                        acc[in_ch[l][IDX_W-1:0]] <= acc[in_ch[l][IDX_W-1:0]] + ACC_WIDTH'(in_data[l]);
                end
            end
        end
    end

    for (genvar g = 0; g < OPS_PER_CYCLE; g++) begin : g_lane
        logic                 in_range;
        logic [ACC_WIDTH-1:0] acc_rd;
        logic [MUL_W-1:0]     prod;
        logic [RND_W-1:0]     rounded;
        logic [RND_W-1:0]     scaled;

        assign in_range = (out_ch[g] < CH_W'(CHANNELS));
        assign acc_rd   = in_range ? acc[out_ch[g][IDX_W-1:0]] : '0;
        assign prod     = MUL_W'(acc_rd) * MUL_W'(RECIP);
        assign rounded  = RND_W'(prod) + RND_W'(2 ** (SHIFT - 1));
        assign scaled   = rounded >> SHIFT;
        assign out_data[g] = (state != OUTPUT || !in_range) ? '0 :
                             (scaled > RND_W'(2 ** DATA_WIDTH - 1)) ? '1 :
                             scaled[DATA_WIDTH-1:0];
    end

endmodule

// File: tb/tb_global_avg_pool.sv
// Randomized and directed frames against a behavioural per-channel average model.
module tb_global_avg_pool;

    localparam int DW     = 8;
    localparam int OPS    = 10;
    localparam int CH     = 1024;
    localparam int PIX    = 49;
    localparam int BEATS  = (CH + OPS - 1) / OPS;
    localparam int RECIP  = 1337;
    localparam int SHIFT  = 16;

    logic                    clock;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [OPS-1:0][DW-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OPS-1:0][DW-1:0]  out_data;
    logic                    out_last;
    logic                    frame_done;

    global_avg_pool #(
        .DATA_WIDTH    (DW),
        .OPS_PER_CYCLE (OPS),
        .CHANNELS      (CH),
        .PIXELS        (PIX),
        .ACC_WIDTH     (16),
        .RECIP         (RECIP),
        .SHIFT         (SHIFT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         cyc = 0;
    int         last_acc_cyc = -10;
    int         ob = 0;
    int         frames_out = 0;
    int         rdy_mode = 0;
    int         stall_left = 0;
    int         sums [CH];
    logic [7:0] got [CH];
    logic [7:0] exp_q [$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name, input logic [79:0] act, input logic [79:0] expv);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic logic [7:0] avg_of(input int s);
        longint r;
        r = (longint'(s) * RECIP + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        return (r > 255) ? 8'd255 : r[7:0];
    endfunction

    function automatic int pix_val(input int mode, input int k, input int p, input int c);
        case (mode)
            0: return k;
            1: return c % 256;
            2: begin
                if (p == 0 && c == 0) return 24;
                if (p == 0 && c == 1) return 25;
                if (p == PIX - 1 && c == 2) return 255;
                return 0;
            end
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Drives npix pixels; the expected vector is queued only for a complete frame.
    task automatic send_frame(input int mode, input int k, input int npix, input bit gaps);
        logic [OPS-1:0][DW-1:0] beat;
        int vals [OPS];
        bit acc_ok;
        int waited;
        for (int p = 0; p < npix; p++) begin
            for (int b = 0; b < BEATS; b++) begin
                for (int l = 0; l < OPS; l++) begin
                    if (b * OPS + l < CH) vals[l] = pix_val(mode, k, p, b * OPS + l);
                    else vals[l] = int'($urandom_range(0, 255));
                    beat[l] = vals[l][7:0];
                end
                acc_ok = 1'b0;
                waited = 0;
                while (!acc_ok) begin
                    @(negedge clock);
                    if (gaps && $urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                    end else begin
                        in_valid = 1'b1;
                        in_data  = beat;
                        if (in_ready) acc_ok = 1'b1;
                    end
                    waited++;
                    if (!acc_ok && waited > 4000) begin
                        chk(1'b0, "in_ready_timeout", 80'(in_ready), 80'd1);
                        in_valid = 1'b0;
                        return;
                    end
                end
                for (int l = 0; l < OPS; l++) begin
                    if (b * OPS + l < CH)
                        sums[b * OPS + l] = ((p == 0) ? 0 : sums[b * OPS + l]) + vals[l];
                end
                if (p == PIX - 1 && b == BEATS - 1) begin
                    last_acc_cyc = cyc;
                    for (int c = 0; c < CH; c++) exp_q.push_back(avg_of(sums[c]));
                end
            end
        end
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_out < target && n < 3000) begin
            @(negedge clock);
            in_valid = 1'b0;
            n++;
        end
        chk(frames_out >= target, "frame_timeout", 80'(frames_out), 80'(target));
    endtask

    // Keeps garbage on the input throughout the output phase; it must be ignored.
    task automatic garbage_until_done();
        int n = 0;
        while (n < 3000) begin
            @(negedge clock);
            n++;
            if (out_valid && out_ready && out_last) begin
                in_valid = 1'b0;
                return;
            end
            in_valid = 1'b1;
            for (int l = 0; l < OPS; l++) in_data[l] = 8'($urandom_range(0, 255));
        end
        in_valid = 1'b0;
        chk(1'b0, "garbage_timeout", 80'(out_valid), 80'd1);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    if (ob == 50 && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = ~out_ready;
                    end
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle compare against the queued expected averages.
    initial begin
        logic [OPS-1:0][DW-1:0] e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk(in_ready === 1'b1 && out_valid === 1'b0 && out_last === 1'b0 &&
                    frame_done === 1'b0 && out_data === '0, "reset_outputs",
                    {in_ready, out_valid, out_last, frame_done, 76'(out_data)}, {1'b1, 79'd0});
                ob = 0;
            end else begin
                if (cyc == last_acc_cyc + 1)
                    chk(out_valid === 1'b1, "out_valid_latency", 80'(out_valid), 80'd1);
                if (out_valid) begin
                    chk(in_ready === 1'b0, "in_ready_in_output", 80'(in_ready), 80'd0);
                    if (exp_q.size() < CH) begin
                        chk(1'b0, "unexpected_out_valid", 80'(out_valid), 80'd0);
                    end else begin
                        for (int l = 0; l < OPS; l++)
                            e[l] = (ob * OPS + l < CH) ? exp_q[ob * OPS + l] : 8'd0;
                        chk(out_data === e, "out_data_beat", out_data, e);
                        chk(out_last === (ob == BEATS - 1), "out_last", 80'(out_last), 80'(ob == BEATS - 1));
                        chk(frame_done === (out_ready && ob == BEATS - 1), "frame_done",
                            80'(frame_done), 80'(out_ready && ob == BEATS - 1));
                        if (out_ready) begin
                            for (int l = 0; l < OPS; l++)
                                if (ob * OPS + l < CH) got[ob * OPS + l] = out_data[l];
                            if (ob == BEATS - 1) begin
                                ob = 0;
                                for (int c = 0; c < CH; c++) void'(exp_q.pop_front());
                                frames_out++;
                            end else begin
                                ob++;
                            end
                        end
                    end
                end else begin
                    chk(in_ready === 1'b1 && frame_done === 1'b0, "accum_handshake",
                        {78'd0, in_ready, frame_done}, 80'd2);
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        send_frame(0, 255, PIX, 1'b0);
        wait_frames(1);
        chk(got[0] == 8'd255, "lit_all255_ch0", 80'(got[0]), 80'd255);
        chk(got[1023] == 8'd255, "lit_all255_ch1023", 80'(got[1023]), 80'd255);

        send_frame(1, 0, PIX, 1'b0);
        wait_frames(2);
        chk(got[300] == 8'd44, "lit_cmod_ch300", 80'(got[300]), 80'd44);
        chk(got[1023] == 8'd255, "lit_cmod_ch1023", 80'(got[1023]), 80'd255);

        send_frame(2, 0, PIX, 1'b0);
        wait_frames(3);
        chk(got[0] == 8'd0, "lit_round_24", 80'(got[0]), 80'd0);
        chk(got[1] == 8'd1, "lit_round_25", 80'(got[1]), 80'd1);
        chk(got[2] == 8'd5, "lit_round_255_last", 80'(got[2]), 80'd5);

        rdy_mode   = 1;
        stall_left = 10;
        send_frame(3, 0, PIX, 1'b1);
        garbage_until_done();
        wait_frames(4);
        rdy_mode = 0;

        send_frame(0, 200, PIX, 1'b0);
        send_frame(0, 7, PIX, 1'b0);
        wait_frames(6);
        chk(got[0] == 8'd7, "lit_b2b_ch0", 80'(got[0]), 80'd7);
        chk(got[1023] == 8'd7, "lit_b2b_ch1023", 80'(got[1023]), 80'd7);

        rdy_mode = 2;
        send_frame(0, 100, 20, 1'b0);
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b1;
        repeat (4) @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        send_frame(0, 50, PIX, 1'b1);
        wait_frames(7);
        chk(got[512] == 8'd50, "lit_reset_ch512", 80'(got[512]), 80'd50);

        send_frame(3, 0, PIX, 1'b1);
        wait_frames(8);
        rdy_mode = 0;
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
